// File: rtl/pe_spad_pkg.sv
// Shared definitions for the PE input-activation scratchpad loader:
// load FSM states, default stream widths/depths and the end-of-stream word.
package pe_spad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam int DEF_DATA_WIDTH = 12;  // 8-bit activation + 4-bit count
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_DEPTH = 16;
  localparam int DEF_ADDR_DEPTH = 9;

  // An all-zero word marks the end of a CSC stream.
  localparam int TERMINATOR_WORD = 0;

endpackage

// File: rtl/pe_spad_stream_writer.sv
// One CSC stream into one scratchpad: write index, loaded length,
// terminated flag, full detection and a registered SPad write port.
// The index saturates at DEPTH; beats arriving while full are not written.
module pe_spad_stream_writer
  import pe_spad_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DATA_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,      // start of a new load
  input  logic                         active,     // FSM is in LOAD
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_word,
  output logic                         spad_we,
  output logic [$clog2(DEPTH)-1:0]     spad_waddr,
  output logic [WIDTH-1:0]             spad_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   len,
  output logic                         term_next,  // terminated after this edge
  output logic                         overflow,   // beat accepted while full
  output logic                         stray       // beat after the terminator
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    len_q, len_d;
  logic             term_q, term_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic accept;
  logic full;
  logic is_term;

  // Beat acceptance, index/length bookkeeping and write-port staging.
  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    term_d  = term_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    accept  = active && in_valid && !term_q;
    full    = (idx_q == IW'(DEPTH));
    is_term = (in_word == WIDTH'(TERMINATOR_WORD));

    if (clear) begin
      idx_d  = '0;
      len_d  = '0;
      term_d = 1'b0;
    end else if (accept) begin
      if (!full) begin
        we_d    = 1'b1;
        waddr_d = idx_q[AW-1:0];
        wdata_d = in_word;
        idx_d   = idx_q + IW'(1);
        if (!is_term) begin
          len_d = len_q + IW'(1);
        end
      end
      // A terminator ends the stream even when it could not be stored.
      if (is_term) begin
        term_d = 1'b1;
      end
    end
  end

  // State and registered SPad write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      len_q   <= '0;
      term_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      len_q   <= len_d;
      term_q  <= term_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign spad_we    = we_q;
  assign spad_waddr = waddr_q;
  assign spad_wdata = wdata_q;
  assign len        = len_q;
  assign term_next  = term_d;
  assign overflow   = accept && full;
  assign stray      = active && in_valid && term_q;

endmodule

// File: rtl/pe_iact_spad_loader.sv
// Loads the PE input-activation address and data streams into their
// scratchpads and reports the loaded lengths. Streams have no back-pressure:
// every valid beat in LOAD is taken the cycle it appears.
// Optional build macro PE_SPAD_ERR_EN: builds the sticky err_overflow /
// err_unexpected flags; otherwise both error outputs are tied low.
module pe_iact_spad_loader
  import pe_spad_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int ADDR_DEPTH = DEF_ADDR_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              addr_in_valid,
  input  logic [ADDR_WIDTH-1:0]             addr_in,
  input  logic                              data_in_valid,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic                              addr_spad_we,
  output logic [$clog2(ADDR_DEPTH)-1:0]     addr_spad_waddr,
  output logic [ADDR_WIDTH-1:0]             addr_spad_wdata,
  output logic                              data_spad_we,
  output logic [$clog2(DATA_DEPTH)-1:0]     data_spad_waddr,
  output logic [DATA_WIDTH-1:0]             data_spad_wdata,
  output logic [$clog2(ADDR_DEPTH+1)-1:0]   addr_len,
  output logic [$clog2(DATA_DEPTH+1)-1:0]   data_len,
  output logic                              busy,
  output logic                              load_done,
  output logic                              err_overflow,
  output logic                              err_unexpected
);

  load_state_e state_q, state_d;
  logic        clear;
  logic        active;
  logic        addr_term_next, data_term_next;
  logic        addr_ovf, data_ovf;
  logic        addr_stray, data_stray;

  pe_spad_stream_writer #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (ADDR_DEPTH)
  ) u_addr_writer (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .active     (active),
    .in_valid   (addr_in_valid),
    .in_word    (addr_in),
    .spad_we    (addr_spad_we),
    .spad_waddr (addr_spad_waddr),
    .spad_wdata (addr_spad_wdata),
    .len        (addr_len),
    .term_next  (addr_term_next),
    .overflow   (addr_ovf),
    .stray      (addr_stray)
  );

  pe_spad_stream_writer #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DATA_DEPTH)
  ) u_data_writer (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .active     (active),
    .in_valid   (data_in_valid),
    .in_word    (data_in),
    .spad_we    (data_spad_we),
    .spad_waddr (data_spad_waddr),
    .spad_wdata (data_spad_wdata),
    .len        (data_len),
    .term_next  (data_term_next),
    .overflow   (data_ovf),
    .stray      (data_stray)
  );

  // Next-state and status outputs. Moving to DONE on the terminated flags'
  // next values lines load_done up with the last terminator's SPad write.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    active    = (state_q == LOAD);
    busy      = (state_q == LOAD);
    load_done = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clear   = 1'b1;
        end
      end
      LOAD: begin
        if (addr_term_next && data_term_next) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PE_SPAD_ERR_EN
  logic err_overflow_q, err_overflow_d;
  logic err_unexpected_q, err_unexpected_d;

  // Sticky error flags; a new load clears them, but a stray beat that
  // coincides with start is still recorded.
  always_comb begin
    err_overflow_d   = (clear ? 1'b0 : err_overflow_q) | addr_ovf | data_ovf;
    err_unexpected_d = (clear ? 1'b0 : err_unexpected_q) | addr_stray | data_stray
                       | (!active && (addr_in_valid || data_in_valid));
  end

  // Error flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow_q   <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      err_overflow_q   <= err_overflow_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  assign err_overflow   = err_overflow_q;
  assign err_unexpected = err_unexpected_q;
`else
  logic unused_err_sources;
  assign unused_err_sources = addr_ovf ^ data_ovf ^ addr_stray ^ data_stray;
  assign err_overflow       = 1'b0;
  assign err_unexpected     = 1'b0;
`endif

endmodule

// File: tb/tb_pe_iact_spad_loader.sv
// Directed bench for pe_iact_spad_loader: basic load, simultaneous
// terminators, data overflow, stray beats and reset mid-load.
// Error-flag expectations follow the PE_SPAD_ERR_EN build macro.
module tb_pe_iact_spad_loader;

`ifdef PE_SPAD_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic        addr_in_valid;
  logic [3:0]  addr_in;
  logic        data_in_valid;
  logic [11:0] data_in;
  logic        addr_spad_we;
  logic [3:0]  addr_spad_waddr;
  logic [3:0]  addr_spad_wdata;
  logic        data_spad_we;
  logic [3:0]  data_spad_waddr;
  logic [11:0] data_spad_wdata;
  logic [3:0]  addr_len;
  logic [4:0]  data_len;
  logic        busy;
  logic        load_done;
  logic        err_overflow;
  logic        err_unexpected;

  pe_iact_spad_loader dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .addr_in_valid   (addr_in_valid),
    .addr_in         (addr_in),
    .data_in_valid   (data_in_valid),
    .data_in         (data_in),
    .addr_spad_we    (addr_spad_we),
    .addr_spad_waddr (addr_spad_waddr),
    .addr_spad_wdata (addr_spad_wdata),
    .data_spad_we    (data_spad_we),
    .data_spad_waddr (data_spad_waddr),
    .data_spad_wdata (data_spad_wdata),
    .addr_len        (addr_len),
    .data_len        (data_len),
    .busy            (busy),
    .load_done       (load_done),
    .err_overflow    (err_overflow),
    .err_unexpected  (err_unexpected)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Write/done log collected by the monitor.
  int a_cnt, d_cnt, done_cnt, done_cyc;
  int a_addr [64];
  int a_data [64];
  int a_cyc  [64];
  int d_addr [64];
  int d_data [64];
  int d_cyc  [64];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: sample away from the active edge, one line per SPad write.
  always @(negedge clock) begin
    if (addr_spad_we && a_cnt < 64) begin
      a_addr[a_cnt] = int'(addr_spad_waddr);
      a_data[a_cnt] = int'(addr_spad_wdata);
      a_cyc[a_cnt]  = cyc;
      $display("cyc %0d addr_spad write idx=%0d data=0x%0h", cyc, addr_spad_waddr, addr_spad_wdata);
      a_cnt++;
    end
    if (data_spad_we && d_cnt < 64) begin
      d_addr[d_cnt] = int'(data_spad_waddr);
      d_data[d_cnt] = int'(data_spad_wdata);
      d_cyc[d_cnt]  = cyc;
      $display("cyc %0d data_spad write idx=%0d data=0x%0h", cyc, data_spad_waddr, data_spad_wdata);
      d_cnt++;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("cyc %0d load_done addr_len=%0d data_len=%0d", cyc, addr_len, data_len);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_log();
    a_cnt    = 0;
    d_cnt    = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic av, input logic [3:0] a, input logic dv, input logic [11:0] d);
    addr_in_valid = av;
    addr_in       = a;
    data_in_valid = dv;
    data_in       = d;
    step();
    addr_in_valid = 1'b0;
    addr_in       = '0;
    data_in_valid = 1'b0;
    data_in       = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},      int'(busy), 0);
    check({pfx, "_done"},      int'(load_done), 0);
    check({pfx, "_a_we"},      int'(addr_spad_we), 0);
    check({pfx, "_d_we"},      int'(data_spad_we), 0);
    check({pfx, "_a_waddr"},   int'(addr_spad_waddr), 0);
    check({pfx, "_d_waddr"},   int'(data_spad_waddr), 0);
    check({pfx, "_d_wdata"},   int'(data_spad_wdata), 0);
    check({pfx, "_addr_len"},  int'(addr_len), 0);
    check({pfx, "_data_len"},  int'(data_len), 0);
    check({pfx, "_err_ovf"},   int'(err_overflow), 0);
    check({pfx, "_err_unexp"}, int'(err_unexpected), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    addr_in_valid = 1'b0; addr_in = '0;
    data_in_valid = 1'b0; data_in = '0;
    clear_log();
    repeat (3) step();

    // Reset state
    check_all_zero("rst");
    reset = 1'b0;
    step();

    // Basic load: addr 3,5,0 and data 0x101,0x202,0x303,0
    clear_log();
    pulse_start();
    check("basic_busy", int'(busy), 1);
    beat(1, 4'd3, 1, 12'h101);
    beat(1, 4'd5, 1, 12'h202);
    beat(1, 4'd0, 1, 12'h303);
    beat(0, 4'd0, 1, 12'h000);
    step(); step();
    check("basic_a_cnt", a_cnt, 3);
    check("basic_a0", a_addr[0] * 256 + a_data[0], 0 * 256 + 3);
    check("basic_a1", a_addr[1] * 256 + a_data[1], 1 * 256 + 5);
    check("basic_a2", a_addr[2] * 256 + a_data[2], 2 * 256 + 0);
    check("basic_d_cnt", d_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_d%0d_idx", i), d_addr[i], i);
    end
    check("basic_d0", d_data[0], 12'h101);
    check("basic_d1", d_data[1], 12'h202);
    check("basic_d2", d_data[2], 12'h303);
    check("basic_d3", d_data[3], 0);
    check("basic_back2back", d_cyc[3] - d_cyc[0], 3);
    check("basic_addr_len", int'(addr_len), 2);
    check("basic_data_len", int'(data_len), 3);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_cyc", done_cyc, d_cyc[3]);
    check("basic_err_ovf", int'(err_overflow), 0);
    check("basic_err_unexp", int'(err_unexpected), 0);
    check("basic_idle", int'(busy), 0);

    // Simultaneous terminators
    clear_log();
    pulse_start();
    beat(1, 4'd7, 1, 12'h011);
    beat(1, 4'd0, 1, 12'h000);
    step(); step();
    check("simul_done_cnt", done_cnt, 1);
    check("simul_done_cyc_a", done_cyc, a_cyc[1]);
    check("simul_done_cyc_d", done_cyc, d_cyc[1]);
    check("simul_addr_len", int'(addr_len), 1);
    check("simul_data_len", int'(data_len), 1);

    // Data overflow: 17 non-zero data beats then a terminator
    clear_log();
    pulse_start();
    beat(1, 4'd1, 1, 12'h010);
    for (int i = 1; i < 17; i++) begin
      beat(0, 4'd0, 1, 12'(16 + i));
    end
    beat(0, 4'd0, 1, 12'h000);
    step();
    check("ovf_no_done_yet", done_cnt, 0);
    check("ovf_still_busy", int'(busy), 1);
    beat(1, 4'd0, 0, 12'h000);
    step(); step();
    check("ovf_d_cnt", d_cnt, 16);
    check("ovf_d0", d_addr[0] * 4096 + d_data[0], 0 * 4096 + 16);
    check("ovf_d15", d_addr[15] * 4096 + d_data[15], 15 * 4096 + 31);
    check("ovf_data_len", int'(data_len), 16);
    check("ovf_addr_len", int'(addr_len), 1);
    check("ovf_a_cnt", a_cnt, 2);
    check("ovf_done_cnt", done_cnt, 1);
    check("ovf_err_ovf", int'(err_overflow), ERR_EN);
    check("ovf_err_unexp", int'(err_unexpected), 0);

    // Stray beats: data beat in IDLE, then addr beat after its terminator
    clear_log();
    beat(0, 4'd0, 1, 12'h055);
    step();
    check("stray_idle_no_write", d_cnt, 0);
    check("stray_idle_err", int'(err_unexpected), ERR_EN);
    pulse_start();
    check("stray_start_clr_unexp", int'(err_unexpected), 0);
    check("stray_start_clr_ovf", int'(err_overflow), 0);
    beat(1, 4'd0, 0, 12'h000);
    beat(1, 4'd4, 0, 12'h000);
    beat(0, 4'd0, 1, 12'h005);
    beat(0, 4'd0, 1, 12'h000);
    step(); step();
    check("stray_a_cnt", a_cnt, 1);
    check("stray_d_cnt", d_cnt, 2);
    check("stray_addr_len", int'(addr_len), 0);
    check("stray_err", int'(err_unexpected), ERR_EN);
    check("stray_done_cnt", done_cnt, 1);
    pulse_start();
    check("stray_clr_next_start", int'(err_unexpected), 0);

    // Reset mid-load after 2 data beats (still in LOAD from the start above)
    beat(0, 4'd0, 1, 12'h0A1);
    beat(0, 4'd0, 1, 12'h0A2);
    reset = 1'b1;
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    step();
    clear_log();
    pulse_start();
    beat(1, 4'd0, 1, 12'h777);
    beat(0, 4'd0, 1, 12'h000);
    step(); step();
    check("reload_d_cnt", d_cnt, 2);
    check("reload_d0_idx", d_addr[0], 0);
    check("reload_d0_data", d_data[0], 12'h777);
    check("reload_a0_idx", a_addr[0], 0);
    check("reload_data_len", int'(data_len), 1);
    check("reload_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_iact_spad_loader.md
# pe_iact_spad_loader

Consumes the two PE input-activation streams (CSC address words and CSC data words) leaving the per-PE data FIFOs. Writes every beat into the address and data scratchpads, and detects the zero-word end-of-stream markers. Reports the loaded lengths to the PE control FSM. The upstream FIFOs have no back-pressure, so this block must accept a beat on every cycle its valid is high.

## Interface
Parameters:
- DATA_WIDTH, 12: data word width (8-bit activation + 4-bit count)
- ADDR_WIDTH, 4: address word width
- DATA_DEPTH, 16: data SPad entries
- ADDR_DEPTH, 9: address SPad entries

Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  pulse; begins a load
- addr_in_valid  in  1  address beat valid (from address FIFO data_out_valid)
- addr_in  in  ADDR_WIDTH  address beat
- data_in_valid  in  1  data beat valid
- data_in  in  DATA_WIDTH  data beat
- addr_spad_we  out  1  address SPad write enable
- addr_spad_waddr  out  $clog2(ADDR_DEPTH)  write index
- addr_spad_wdata  out  ADDR_WIDTH  write data
- data_spad_we  out  1  data SPad write enable
- data_spad_waddr  out  $clog2(DATA_DEPTH)  write index
- data_spad_wdata  out  DATA_WIDTH  write data
- addr_len  out  $clog2(ADDR_DEPTH+1)  address words loaded, terminator excluded
- data_len  out  $clog2(DATA_DEPTH+1)  data words loaded, terminator excluded
- busy  out  1  high in LOAD
- load_done  out  1  one-cycle pulse when both streams have terminated
- err_overflow  out  1  sticky; a beat arrived with its SPad full
- err_unexpected  out  1  sticky; a beat arrived outside LOAD

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on start. On entry, clear both write indices, both lengths and both per-stream terminated flags.
- LOAD, per stream, independently:
  - A valid beat writes the SPad at the current index, then the index increments.
  - A non-zero beat increments its length.
  - An all-zero beat is the terminator. It is written, it sets the terminated flag, and the length does not change.
  - Beats after that stream's terminator are dropped and set err_unexpected.
- LOAD -> DONE when both terminated flags are set. This includes the case where both terminators arrive in the same cycle.
- DONE -> IDLE unconditionally after one cycle. load_done is high only in DONE.
- start in LOAD or DONE is ignored.
- Full SPad: when index == DEPTH, the beat (terminator included) is not written and err_overflow is set.
  - An overflowing terminator still sets the terminated flag.
  - The index saturates at DEPTH; it never wraps.
- Beats in IDLE or DONE are dropped and set err_unexpected.
- Error flags clear only on reset or on the IDLE -> LOAD transition.
- addr_len and data_len hold their values through IDLE until the next start.

## Timing
- Reset values:
  - All outputs 0 and state IDLE.
  - Write indices 0.
  - Lengths 0.
- SPad write port is registered: a beat accepted at edge N drives we/waddr/wdata during cycle N+1.
- Back-to-back beats on consecutive cycles produce writes on consecutive cycles. There is no bubble.
- A beat in the same cycle as start (while IDLE) is dropped and flagged.
- A beat on the first LOAD cycle (cycle after start) is accepted.
- load_done asserts the cycle after the last terminator is accepted, coincident with that terminator's SPad write.
- Reset mid-LOAD: the next cycle returns to IDLE with all outputs 0. Any partial SPad contents are abandoned.

## Configuration
- PE_SPAD_ERR_EN defined: err_overflow and err_unexpected logic is built as specified.
- Not defined:
  - Both error ports are tied 0.
  - The overflow write suppression and index saturation are still built. Only the flags are removed.

## Structure
- Shared package pe_spad_pkg holds:
  - the FSM state enum (IDLE/LOAD/DONE)
  - default widths and depths
  - the terminator constant (all-zero word)
- One sub-module, pe_spad_stream_writer, parameterised by width and depth. It holds the index, length, terminated flag, overflow detect and registered write port. It is instantiated twice, once per stream. The top level holds the FSM and error aggregation.

## Test plan
- Basic load: start, then addr 3,5,0 and data 0x101,0x202,0x303,0 over consecutive cycles. Required: 3 address writes at indices 0..2 and 4 data writes at indices 0..3; addr_len=2, data_len=3; a single load_done pulse; no errors.
- Simultaneous terminators: both zero words on the same cycle. Required: load_done exactly once, one cycle later.
- Data overflow: 17 non-zero data beats then a terminator. Required:
  - 16 writes, indices 0..15.
  - 17th beat and terminator not written.
  - data_len=16, err_overflow=1 (with PE_SPAD_ERR_EN).
  - load_done still asserted after the address stream terminates.
- Stray beats: data beat in IDLE, and addr beat after the addr terminator. Required: no SPad write and err_unexpected=1. Both errors clear on the next start.
- Reset mid-load: reset after 2 data beats. Required: all outputs 0 on the following cycle and state IDLE; a subsequent start reloads from index 0.
- Macro off: repeat the overflow test. Required: writes are identical to the macro-on run, and err_overflow stays 0.
